// File: rtl/io_port_responder.sv
// CPU port-bus peripheral: LED latch, TX FIFO with valid/ready drain, control and status ports.
// Define IO_OVF_STICKY_EN to add the sticky overflow flag (status bit2, cleared by CTRL bit1).
module io_port_responder #(
    parameter int          DEPTH     = 8,
    parameter logic [15:0] PORT_LED  = 16'h0001,
    parameter logic [15:0] PORT_TX   = 16'h0002,
    parameter logic [15:0] PORT_CTRL = 16'h0003,
    parameter logic [15:0] PORT_STAT = 16'h0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        wr_stb,
    output logic [15:0] rd_data,
    output logic [15:0] led,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   led_q, led_d;
    logic [15:0]   rd_data_q, rd_data_d;

    logic        wr_led, wr_tx, wr_ctrl;
    logic        empty, full, pop, push_ok, flush, mem_we;
    logic        ovf;
    logic [15:0] status;

    always_comb begin
        wr_led  = wr_stb && (addr == PORT_LED);
        wr_tx   = wr_stb && (addr == PORT_TX);
        wr_ctrl = wr_stb && (addr == PORT_CTRL);

        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        pop     = !empty && tx_ready;
        // A full FIFO still accepts a push when the same edge pops a word.
        push_ok = wr_tx && (!full || pop);
        flush   = wr_ctrl && wdata[0];
        mem_we  = push_ok && !flush;
    end

    always_comb begin
        led_d = wr_led ? wdata : led_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push_ok);
            count_d  = count_q + CW'(push_ok) - CW'(pop);
        end
    end

    // Status is built from pre-edge state so a read never sees this edge's updates.
    always_comb begin
        status = {8'(count_q), 5'b0, ovf, full, empty};

        if (addr == PORT_LED) begin
            rd_data_d = led_q;
        end else if (addr == PORT_STAT) begin
            rd_data_d = status;
        end else begin
            rd_data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            led_q     <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            led_q     <= led_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage needs no reset: a word is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

`ifdef IO_OVF_STICKY_EN
    logic ovf_q, ovf_d;
    logic ovf_evt, ovf_clr;

    always_comb begin
        ovf_evt = wr_tx && full && !pop;
        ovf_clr = wr_ctrl && wdata[1];
        ovf_d   = ovf_q;
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end
        // Clear is applied last so it wins over a simultaneous overflow.
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign rd_data  = rd_data_q;
    assign led      = led_q;
    assign tx_data  = mem_q[rd_ptr_q];
    assign tx_valid = !empty;

endmodule
